// File: rtl/branch_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline with branches resolved in ID.
// Outputs are combinational from state and inputs; there is no handshake, and the pipeline obeys the enables every cycle.
module branch_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             branch_taken,
    input  logic [4:0]       ex_rw,
    input  logic             ex_regWr,
    input  logic             ex_memtoreg,
    input  logic [4:0]       mem_rw,
    input  logic             mem_memtoreg,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, STALL} state_t;

    state_t     state;
    logic [1:0] rem;
    logic       rs_ex, rt_ex, rs_mem, rt_mem, dep_ex, dep_mem;
    logic [1:0] n_req;

    // $0 is hard-wired, so a write to it never produces a dependency.
    assign rs_ex   = id_use_rs && (ex_rw  != 5'd0) && (ex_rw  == id_rs);
    assign rt_ex   = id_use_rt && (ex_rw  != 5'd0) && (ex_rw  == id_rt);
    assign rs_mem  = id_use_rs && (mem_rw != 5'd0) && (mem_rw == id_rs);
    assign rt_mem  = id_use_rt && (mem_rw != 5'd0) && (mem_rw == id_rt);
    assign dep_ex  = rs_ex  || rt_ex;
    assign dep_mem = rs_mem || rt_mem;

    always_comb begin
        n_req = 2'd0;
        if (id_branch && ex_memtoreg && dep_ex)
            n_req = 2'd2;
        else if (id_branch && ex_regWr && dep_ex)
            n_req = 2'd1;
        else if (id_branch && mem_memtoreg && dep_mem)
            n_req = 2'd1;
        else if (!id_branch && ex_memtoreg && dep_ex)
            n_req = 2'd1;
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            if (state == STALL) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
                busy        = 1'b1;
            end else if (n_req != 2'd0) begin
                // An unresolved operand suppresses any flush, even on a taken branch.
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else begin
                ifid_flush  = (id_branch && branch_taken) || id_jump;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            rem         <= 2'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (n_req == 2'd2) begin
                        state <= STALL;
                        rem   <= 2'd1;
                    end
                end
                STALL: begin
                    // rem counts the STALL cycles left including the current one.
                    if (rem <= 2'd1)
                        state <= RUN;
                    if (rem != 2'd0)
                        rem <= rem - 2'd1;
                end
                default: state <= RUN;
            endcase

            if (!pc_write && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
            if (ifid_flush && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule
